// File: rtl/xdma_axi_tx.sv
`default_nettype none
// ============================================================================
// Module   : xdma_axi_tx
// Brief    : Card-to-host AXI-stream transmit packer. Packs narrow difftest
//            chunks little-endian into 512-bit beats, queues the beats in a
//            small FIFO and presents them with tlast on each packet's last
//            beat.
// Options  : XDMA_TX_FLUSH_TIMEOUT_EN - flush a partial beat (tlast=1) after
//            TIMEOUT idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module xdma_axi_tx #(
  parameter int IN_WIDTH = 128,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_last,
  output logic [511:0]        axi_tdata,
  output logic                axi_tlast,
  output logic                axi_tvalid,
  input  logic                axi_tready
);

  localparam int c_ratio = 512 / IN_WIDTH;
  localparam int c_idx_w = (c_ratio > 1) ? $clog2(c_ratio) : 1;
  localparam int c_ptr_w = $clog2(DEPTH) + 1;
  localparam int c_adr_w = c_ptr_w - 1;

  // Elaboration-time guard on the parameter ranges.
  generate
    if (!(IN_WIDTH == 64 || IN_WIDTH == 128 || IN_WIDTH == 256 || IN_WIDTH == 512) ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("xdma_axi_tx: illegal parameter set");
    end
  endgenerate

  // Packer state
  logic [511:0]         r_pack_data;
  logic [c_idx_w-1:0]   r_pack_idx;

  // Beat FIFO state: one extra bit per entry carries tlast
  logic [512:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_count;

  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_flush_now;
  logic                 w_accept;
  logic                 w_last_lane;
  logic                 w_beat_done;
  logic                 w_push;
  logic                 w_pop;
  logic [511:0]         w_merged;
  logic [512:0]         w_push_entry;
  logic [512:0]         w_head;

  assign w_fifo_full  = (r_count == c_ptr_w'(DEPTH));
  assign w_fifo_empty = (r_count == '0);

  // in_ready is a function of registered state only
  assign in_ready    = ~w_fifo_full & ~w_flush_now;
  assign w_accept    = in_valid & in_ready;
  assign w_last_lane = (r_pack_idx == c_idx_w'(c_ratio - 1));
  assign w_beat_done = w_accept & (w_last_lane | in_last);
  assign w_push      = w_beat_done | w_flush_now;
  assign w_pop       = ~w_fifo_empty & axi_tready;

  // Current partial beat with the incoming chunk dropped into its lane;
  // lanes above it are already zero because the packer clears on completion.
  always_comb begin
    w_merged = r_pack_data;
    w_merged[int'(r_pack_idx) * IN_WIDTH +: IN_WIDTH] = in_data;
  end

  // A chunk-completed beat takes tlast from in_last (forced 1 whenever in_last
  // ends the beat early, equal to in_last on a full beat); a flush always ends
  // the packet. Flush and accept never coincide because flush blocks in_ready.
  always_comb begin
    w_push_entry = {in_last, w_merged};
    if (w_flush_now) begin
      w_push_entry = {1'b1, r_pack_data};
    end
  end

`ifdef XDMA_TX_FLUSH_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_idle;

  assign w_flush_now = (r_idle == c_cnt_w'(TIMEOUT)) & ~w_fifo_full;

  // Idle counter: runs only while a partial beat sits in the packer and
  // nothing is accepted; holds at TIMEOUT while the FIFO blocks the flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idle <= '0;
    end else if (w_accept || (r_pack_idx == '0) || w_flush_now) begin
      r_idle <= '0;
    end else if (r_idle != c_cnt_w'(TIMEOUT)) begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_flush_now = 1'b0;
`endif

  // Packer register: accumulate chunks, clear once the beat goes to the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pack_data <= '0;
      r_pack_idx  <= '0;
    end else if (w_push) begin
      r_pack_data <= '0;
      r_pack_idx  <= '0;
    end else if (w_accept) begin
      r_pack_data <= w_merged;
      r_pack_idx  <= r_pack_idx + 1'b1;
    end
  end

  // FIFO storage: payload only, no reset needed since reads are gated by
  // occupancy.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_adr_w-1:0]] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at 2*DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is only exposed while valid, so outputs read zero when empty.
  assign w_head     = w_fifo_empty ? '0 : r_mem[r_rd_ptr[c_adr_w-1:0]];
  assign axi_tvalid = ~w_fifo_empty;
  assign axi_tdata  = w_head[511:0];
  assign axi_tlast  = w_head[512];

endmodule
`default_nettype wire
